// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into key events and queues them.
// Define PS2_KBD_RX_ERRCNT_EN to add the saturating err_count output.
module ps2_kbd_rx #(
  parameter int FIFO_BITS = 3,
  parameter int TIMEOUT   = 20000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  input  logic       key_ack,
  output logic       parity_err,
  output logic       frame_timeout,
  output logic       overflow
`ifdef PS2_KBD_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [FIFO_BITS:0] PTR_ONE = (FIFO_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced clock
  logic clk_sync_p0, clk_sync_p1, clk_prev_p2;
  logic data_sync_p0, data_sync_p1;
  logic fall, din;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      clk_prev_p2  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_kbd_clk;
      clk_sync_p1  <= clk_sync_p0;
      clk_prev_p2  <= clk_sync_p1;
      data_sync_p0 <= ps2_kbd_data;
      data_sync_p1 <= data_sync_p0;
    end
  end

  assign fall = clk_prev_p2 & ~clk_sync_p1;
  assign din  = data_sync_p1;

  // Frame FSM
  state_t           state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             err_set, tmo_set, strobe_set, shift_en, par_en;

  // No edge arrives in the cycle the timeout fires, so the two never collide
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!din) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_set    = 1'b0;
    tmo_set    = tmo_hit;
    strobe_set = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    err_set = din;
        DATA:    shift_en = 1'b1;
        PARITY:  par_en = 1'b1;
        STOP: begin
          if (din && (^{shift, par_bit})) strobe_set = 1'b1;
          else                            err_set    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE)  bit_cnt <= 3'd0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (shift_en) shift   <= {din, shift[7:1]};
    if (par_en)   par_bit <= din;
  end

  // Stage p1: registered byte strobe and error pulses
  logic       vld_p1;
  logic [7:0] byte_p1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      parity_err    <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      vld_p1        <= strobe_set;
      parity_err    <= err_set;
      frame_timeout <= tmo_set;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (strobe_set) byte_p1 <= shift;
  end

  // Prefix decoder feeding the event FIFO
  logic       ext_flag, rel_flag;
  logic       is_e0, is_f0, push;
  logic [9:0] push_entry;

  assign is_e0      = (byte_p1 == 8'hE0);
  assign is_f0      = (byte_p1 == 8'hF0);
  assign push       = vld_p1 && !is_e0 && !is_f0;
  assign push_entry = {rel_flag, ext_flag, byte_p1};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if (vld_p1) begin
      if (is_e0) begin
        ext_flag <= 1'b1;
      end else if (is_f0) begin
        rel_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_BITS:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic               pop, full, accept, head_vld_nxt;

  // key_valid only rises with an entry present, so an ack against it always pops a real one
  assign pop          = key_ack & key_valid;
  assign full         = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
                        (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);
  assign accept       = push && (!full || pop);
  assign rd_ptr_nxt   = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign head_vld_nxt = (wr_ptr != rd_ptr_nxt);

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wr_ptr[FIFO_BITS-1:0]] <= push_entry;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 8'd0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr    <= rd_ptr_nxt;
      key_valid <= head_vld_nxt;
      if (push && !accept) overflow <= 1'b1;
      if (head_vld_nxt) begin
        {key_release, key_ext, key_code} <= mem[rd_ptr_nxt[FIFO_BITS-1:0]];
      end
    end
  end

`ifdef PS2_KBD_RX_ERRCNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk_sys) begin
    if (reset)                            err_count <= 8'd0;
    else if (parity_err || frame_timeout) err_count <= sat_inc(err_count);
  end
`endif

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Receives the PS/2 keyboard stream (clock/data pair) produced by the IO controller's PS/2 emulation and decodes it into key events for the core.
- Frames bytes, checks them, resolves E0/F0 prefixes into make/break events, and buffers events in a small FIFO with a valid/ack handshake.
- Sits directly downstream of the IO controller block; the core's keyboard matrix logic consumes its output.

Parameters:
- FIFO_BITS, 3, log2 of event FIFO depth (default 8 entries).
- TIMEOUT, 20000, clk_sys cycles without a PS/2 clock falling edge before a partial frame is discarded.

Ports:
- clk_sys  in  1  system clock; all logic in this domain.
- reset  in  1  synchronous, active-high reset.
- ps2_kbd_clk  in  1  PS/2 clock, idle high, asynchronous to clk_sys.
- ps2_kbd_data  in  1  PS/2 data, sampled on ps2_kbd_clk falling edge.
- key_valid  out  1  head event present.
- key_code  out  8  scan code of head event.
- key_ext  out  1  head event was E0-prefixed.
- key_release  out  1  head event was F0-prefixed (break).
- key_ack  in  1  pops head event when key_valid=1.
- parity_err  out  1  one-cycle pulse on rejected frame (parity, start, or stop error).
- frame_timeout  out  1  one-cycle pulse when a partial frame is aborted.
- overflow  out  1  sticky; set when an event is dropped due to a full FIFO.

Behaviour:
- Reset: all outputs 0; FIFO empty; frame state IDLE; prefix flags cleared; synchronizers loaded with 1.
- Input conditioning:
  - Both pins pass through a 2-flop synchronizer.
  - Falling edge = previous synced clk 1, current synced clk 0; edge is detected in the cycle the synced value first reads 0.
- Frame FSM:
  - IDLE: on falling edge with data=0 go to DATA, bit counter=0. Falling edge with data=1 -> parity_err pulse, stay IDLE.
  - DATA: 8 edges, LSB first into shift register -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: on edge, if data=1 and odd parity over 8 data bits + parity bit holds, emit byte_strobe next cycle; otherwise parity_err pulse. Return to IDLE in both cases.
- Timeout: in any state other than IDLE, a counter is reset on every falling edge.
  - Reaching TIMEOUT -> frame_timeout pulse, return to IDLE, partial byte discarded, prefix flags unchanged.
- Decoder, acting on byte_strobe:
  - E0 -> set ext flag.
  - F0 -> set rel flag.
  - Any other byte -> push {rel, ext, byte} to FIFO, clear both flags.
  - Prefixes never generate events; a repeated prefix is idempotent.
- Latency: with an empty FIFO, key_valid rises exactly 3 clk_sys cycles after the cycle in which the stop-bit falling edge is detected (strobe, push, registered head).
- FIFO:
  - Depth 2^FIFO_BITS, entries 10 bits.
  - Pointers are FIFO_BITS+1 wide for the full/empty distinction and wrap naturally.
  - Outputs show the head entry while key_valid=1.
  - key_ack with key_valid=0 is ignored.
  - Push onto a full FIFO: event dropped, overflow set (cleared only by reset), stored entries unchanged.
  - Push and pop in the same cycle when full: the pop frees the slot and the push is accepted, so no overflow.
  - Push into an empty FIFO with simultaneous ack: the ack is ignored (key_valid was 0).
- Reset mid-frame: frame discarded, no pulses, no event.

Optional Feature:
- Macro PS2_KBD_RX_ERRCNT_EN.
- Defined: adds output err_count [7:0].
  - Saturating counter (stops at 255), incremented on every parity_err or frame_timeout pulse; both pulses in the same cycle count as +1.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> one event code=1C ext=0 rel=0; key_valid rises 3 cycles after stop edge; ack -> key_valid=0.
- Bytes E0, F0, 75 -> single event code=75 ext=1 rel=1. A following 1C -> ext=0 rel=0.
- Frame 0x1C with parity bit 1 -> parity_err pulses once, no event; next valid 0x1C still decodes correctly.
- Start bit plus 5 data bits, then clock idle TIMEOUT cycles -> frame_timeout pulse, FSM IDLE; next full frame 0x29 -> event 29.
- 9 make codes, no ack, FIFO_BITS=3 -> 8 events stored, overflow=1; 8 acks return codes 1..8 in order, 9th absent.
- Reset asserted after 4 data bits of 0x5A, then a clean 0x5A frame -> exactly one event 5A, no error pulses; with PS2_KBD_RX_ERRCNT_EN, 300 bad-parity frames -> err_count=255.
